// File: rtl/apb_vec_mac.sv
// APB vector multiply/accumulate engine: A/B byte operand buffers, 16-bit product buffer, running dot product.
// Optional macro ACC_IRQ_EN adds the irq_o port and the CTRL[3] IRQ_EN bit.
//
// state  | meaning
// S_IDLE | waiting for START
// S_RUN  | one element per cycle: product, accumulate, advance idx
// S_DONE | one-cycle tail that raises done (and irq) then returns to idle
module apb_vec_mac #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_ELEM         = 64,
    parameter int ACC_W          = 32
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR
`ifdef ACC_IRQ_EN
    ,
    output logic                      irq_o
`endif
);
    localparam int IW = $clog2(N_ELEM);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            mode_q, mode_d;
    logic [8:0]      len_q, len_d;
    logic [ACC_W-1:0] dot_q, dot_d;
    logic [IW-1:0]   idx_q, idx_d;
`ifdef ACC_IRQ_EN
    logic            irq_en_q, irq_en_d;
    logic            irq_q;
`endif

    logic [7:0]  a_mem [N_ELEM];
    logic [7:0]  b_mem [N_ELEM];
    logic [15:0] r_mem [N_ELEM];

    logic [9:0]    waddr;
    logic [5:0]    k_ab;
    logic [6:0]    k_r;
    logic [IW-1:0] base_ab, base_r;
    logic          sel_ctrl, sel_stat, sel_len, sel_dot, sel_a, sel_b, sel_r;
    logic          wr_en, wr_ok, ctrl_clr_only;
    logic          a_we, b_we, r_we;
    logic [15:0]   prod;
    logic          last;
    logic          unused_bits;

    assign waddr    = PADDR[11:2];
    assign k_ab     = PADDR[7:2];
    assign k_r      = PADDR[8:2];
    assign base_ab  = IW'({k_ab, 2'b00});
    assign base_r   = IW'({k_r, 1'b0});
    assign sel_ctrl = (waddr == 10'd0);
    assign sel_stat = (waddr == 10'd1);
    assign sel_len  = (waddr == 10'd2);
    assign sel_dot  = (waddr == 10'd3);
    assign sel_a    = (PADDR[11:8] == 4'h1) && (int'(k_ab) < N_ELEM / 4);
    assign sel_b    = (PADDR[11:8] == 4'h2) && (int'(k_ab) < N_ELEM / 4);
    assign sel_r    = (PADDR[11:9] == 3'h2) && (int'(k_r) < N_ELEM / 2);
    assign unused_bits = ^PADDR[1:0];

    assign wr_en         = PSEL & PENABLE & PWRITE;
    assign wr_ok         = wr_en & ~busy_q;
    assign ctrl_clr_only = PWDATA[2] & ~PWDATA[0];
    assign a_we          = wr_ok & sel_a;
    assign b_we          = wr_ok & sel_b;

    assign PREADY  = 1'b1;
    // CLR_DONE alone is always accepted; everything else that mutates operands or control errors while busy.
    assign PSLVERR = wr_en & busy_q & ((sel_ctrl & ~ctrl_clr_only) | sel_len | sel_a | sel_b);

    assign prod = {8'd0, a_mem[idx_q]} * {8'd0, b_mem[idx_q]};
    assign last = ({{(9 - IW){1'b0}}, idx_q} == len_q - 9'd1);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        mode_d  = mode_q;
        len_d   = len_q;
        dot_d   = dot_q;
        idx_d   = idx_q;
        r_we    = 1'b0;
`ifdef ACC_IRQ_EN
        irq_en_d = irq_en_q;
`endif
        case (state_q)
            S_RUN: begin
                dot_d = dot_q + {{(ACC_W - 16){1'b0}}, prod};
                r_we  = ~mode_q;
                if (last) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        if (wr_ok && sel_ctrl) begin
            mode_d = PWDATA[1];
`ifdef ACC_IRQ_EN
            irq_en_d = PWDATA[3];
`endif
            if (PWDATA[2]) done_d = 1'b0;
            if (PWDATA[0]) begin
                done_d = 1'b0;
                dot_d  = '0;
                idx_d  = '0;
                if (len_q != 9'd0) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
        end else if (wr_en && busy_q && sel_ctrl && PWDATA[2]) begin
            done_d = 1'b0;
        end

        if (wr_ok && sel_len) begin
            len_d = (PWDATA[8:0] > 9'(N_ELEM)) ? 9'(N_ELEM) : PWDATA[8:0];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
            len_q   <= '0;
            dot_q   <= '0;
            idx_q   <= '0;
`ifdef ACC_IRQ_EN
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            dot_q   <= dot_d;
            idx_q   <= idx_d;
`ifdef ACC_IRQ_EN
            irq_en_q <= irq_en_d;
            irq_q    <= done_d & irq_en_d;
`endif
        end
    end

`ifdef ACC_IRQ_EN
    assign irq_o = irq_q;
`endif

    // Buffers carry no reset so an aborted run leaves already-written products intact.
    always_ff @(posedge HCLK) begin
        if (a_we) begin
            for (int j = 0; j < 4; j++) a_mem[base_ab + IW'(j)] <= PWDATA[8*j +: 8];
        end
        if (b_we) begin
            for (int j = 0; j < 4; j++) b_mem[base_ab + IW'(j)] <= PWDATA[8*j +: 8];
        end
        if (r_we) r_mem[idx_q] <= prod;
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            if (sel_ctrl) begin
`ifdef ACC_IRQ_EN
                PRDATA = {28'd0, irq_en_q, 1'b0, mode_q, 1'b0};
`else
                PRDATA = {30'd0, mode_q, 1'b0};
`endif
            end else if (sel_stat) begin
                PRDATA = {30'd0, done_q, busy_q};
            end else if (sel_len) begin
                PRDATA = {23'd0, len_q};
            end else if (sel_dot) begin
                PRDATA = 32'(dot_q);
            end else if (sel_a) begin
                for (int j = 0; j < 4; j++) PRDATA[8*j +: 8] = a_mem[base_ab + IW'(j)];
            end else if (sel_b) begin
                for (int j = 0; j < 4; j++) PRDATA[8*j +: 8] = b_mem[base_ab + IW'(j)];
            end else if (sel_r) begin
                PRDATA = {r_mem[base_r + IW'(1)], r_mem[base_r]};
            end else begin
                PRDATA = 32'hFFFF_FFFF;
            end
        end
    end
endmodule

// File: tb/tb_apb_vec_mac.sv
// Directed bench for apb_vec_mac; a second instance with ACC_W=17 shares the bus to check accumulator wrap.
module tb_apb_vec_mac;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA, PRDATA17;
    logic        PREADY, PSLVERR, PREADY17, PSLVERR17;
`ifdef ACC_IRQ_EN
    logic        irq_o, irq17;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 HCLK = ~HCLK;

    apb_vec_mac dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
`ifdef ACC_IRQ_EN
        , .irq_o(irq_o)
`endif
    );

    apb_vec_mac #(.ACC_W(17)) dut17 (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA17), .PREADY(PREADY17), .PSLVERR(PSLVERR17)
`ifdef ACC_IRQ_EN
        , .irq_o(irq17)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, output logic err);
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(posedge HCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic e;
        apb_wr(a, d, e);
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic [31:0] d17);
        @(negedge HCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1 d = PRDATA; d17 = PRDATA17;
        @(posedge HCLK);
        #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic peek(input logic [11:0] a, output logic [31:0] d, output logic [31:0] d17);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        #1 d = PRDATA; d17 = PRDATA17;
        PSEL = 1'b0;
    endtask

    // Called right after the START write edge; samples STATUS every cycle until done.
    task automatic watch(input int len);
        int n;
        int nb;
        logic [31:0] st;
        n = 0; nb = 0; st = '0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h004;
        while (n < 300) begin
            @(negedge HCLK);
            #1 st = PRDATA;
            n++;
            if (st[0]) nb++;
            if (st[1]) break;
        end
        PSEL = 1'b0;
        chk("done_latency", n, len + 2);
        chk("busy_cycles", nb, len);
        chk("status_end", st, 32'h2);
    endtask

    logic [31:0] d, d17;
    logic        err;
    int          n;

    initial begin
        HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        repeat (3) @(negedge HCLK);
        peek(12'h004, d, d17); chk("rst_status", d, 32'h0);
        peek(12'h00C, d, d17); chk("rst_dot", d, 32'h0); chk("rst_dot17", d17, 32'h0);
        peek(12'h008, d, d17); chk("rst_len", d, 32'h0);
        peek(12'h000, d, d17); chk("rst_ctrl", d, 32'h0);
        chk("rst_prdata_idle", PRDATA, 32'h0);
        chk("rst_slverr", PSLVERR, 32'h0);
        chk("pready", PREADY, 32'h1);
        chk("pready17", PREADY17, 32'h1);
`ifdef ACC_IRQ_EN
        chk("rst_irq", irq_o, 32'h0);
`endif
        @(negedge HCLK);
        HRESETn = 1'b1;

        // basic dot product: products 5,10,15,20
        wr(12'h100, 32'h0403_0201);
        wr(12'h200, 32'h0505_0505);
        wr(12'h008, 32'd4);
        wr(12'h000, 32'h1);
        watch(4);
        rd(12'h400, d, d17); chk("basic_r01", d, 32'h000A_0005);
        rd(12'h404, d, d17); chk("basic_r23", d, 32'h0014_000F);
        rd(12'h00C, d, d17); chk("basic_dot", d, 32'd50); chk("basic_dot17", d17, 32'd50);
        rd(12'h100, d, d17); chk("a_readback", d, 32'h0403_0201);

        rd(12'h800, d, d17); chk("unmapped_800", d, 32'hFFFF_FFFF);
        rd(12'h140, d, d17); chk("unmapped_a_end", d, 32'hFFFF_FFFF);
        rd(12'h480, d, d17); chk("unmapped_r_end", d, 32'hFFFF_FFFF);

        wr(12'h008, 32'd300);
        rd(12'h008, d, d17); chk("len_clamp", d, 32'd64);

        // all operands 0xFF, 64 elements
        for (int k = 0; k < 16; k++) begin
            wr(12'h100 + 12'(4 * k), 32'hFFFF_FFFF);
            wr(12'h200 + 12'(4 * k), 32'hFFFF_FFFF);
        end
        wr(12'h000, 32'h1);
        watch(64);
        for (int k = 0; k < 32; k++) begin
            rd(12'h400 + 12'(4 * k), d, d17);
            chk($sformatf("max_r%0d", k), d, 32'hFE01_FE01);
        end
        rd(12'h00C, d, d17); chk("max_dot", d, 32'd4161600); chk("max_dot17", d17, 32'd98368);

        // MODE=1: accumulate only, R keeps 0xFE01
        wr(12'h100, 32'h0101_0101);
        wr(12'h008, 32'd4);
        wr(12'h000, 32'h3);
        watch(4);
        rd(12'h400, d, d17); chk("mode1_r01", d, 32'hFE01_FE01);
        rd(12'h404, d, d17); chk("mode1_r23", d, 32'hFE01_FE01);
        rd(12'h00C, d, d17); chk("mode1_dot", d, 32'd1020); chk("mode1_dot17", d17, 32'd1020);
        rd(12'h000, d, d17); chk("mode1_ctrl", d, 32'h2);

        // writes while busy are rejected
        wr(12'h000, 32'h0);
        wr(12'h100, 32'h0403_0201);
        wr(12'h200, 32'h0505_0505);
        wr(12'h000, 32'h1);
        apb_wr(12'h200, 32'h0, err); chk("busy_b_slverr", err, 32'h1);
        apb_wr(12'h000, 32'h1, err); chk("busy_start_slverr", err, 32'h1);
        n = 0;
        d = '0;
        while (n < 50 && !d[1]) begin
            rd(12'h004, d, d17);
            n++;
        end
        chk("busy_err_done", d, 32'h2);
        repeat (10) @(negedge HCLK);
        rd(12'h004, d, d17); chk("no_restart", d, 32'h2);
        rd(12'h00C, d, d17); chk("busy_err_dot", d, 32'd50);
        rd(12'h400, d, d17); chk("busy_err_r01", d, 32'h000A_0005);
        rd(12'h404, d, d17); chk("busy_err_r23", d, 32'h0014_000F);
        rd(12'h200, d, d17); chk("busy_err_b", d, 32'h0505_0505);
        apb_wr(12'h00C, 32'h5, err); chk("ro_wr_slverr", err, 32'h0);
        apb_wr(12'h800, 32'h5, err); chk("unmapped_wr_slverr", err, 32'h0);
        rd(12'h00C, d, d17); chk("ro_wr_dropped", d, 32'd50);

        // LEN=0 finishes after one cycle with DOT cleared
        wr(12'h008, 32'd0);
        wr(12'h000, 32'h1);
        watch(0);
        rd(12'h00C, d, d17); chk("len0_dot", d, 32'h0);

        wr(12'h000, 32'h4);
        rd(12'h004, d, d17); chk("clr_done", d, 32'h0);

        // START and CLR_DONE together: run proceeds
        wr(12'h008, 32'd4);
        wr(12'h000, 32'h5);
        watch(4);
        rd(12'h00C, d, d17); chk("start_clr_dot", d, 32'd50);

`ifdef ACC_IRQ_EN
        wr(12'h000, 32'h4);
        wr(12'h000, 32'h9);
        begin
            logic prev_irq;
            prev_irq = 1'b0;
            n = 0;
            PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h004;
            d = '0;
            while (n < 50 && !d[1]) begin
                prev_irq = irq_o;
                @(negedge HCLK);
                #1 d = PRDATA;
                n++;
            end
            PSEL = 1'b0;
            chk("irq_before_done", prev_irq, 32'h0);
            chk("irq_with_done", irq_o, 32'h1);
        end
        wr(12'h000, 32'hC);
        chk("irq_cleared", irq_o, 32'h0);
        rd(12'h000, d, d17); chk("irq_en_readback", d, 32'h8);
        rd(12'h004, d, d17); chk("irq_clr_status", d, 32'h0);
`else
        wr(12'h000, 32'h8);
        rd(12'h000, d, d17); chk("irq_en_absent", d, 32'h0);
`endif

        // reset mid-run
        wr(12'h008, 32'd64);
        wr(12'h000, 32'h1);
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b0;
        peek(12'h004, d, d17); chk("midrst_status", d, 32'h0);
        peek(12'h00C, d, d17); chk("midrst_dot", d, 32'h0); chk("midrst_dot17", d17, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        rd(12'h008, d, d17); chk("midrst_len", d, 32'h0);
        rd(12'h004, d, d17); chk("midrst_idle", d, 32'h0);
        chk("slverr17_idle", PSLVERR17, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
